// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding data-memory responder with configurable access latency
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem [DEPTH];
  logic        mem_we;
  logic        addr_err;
  logic [AW-1:0] idx;

  // Word index and error check on the latched address; upper bits only feed the range test.
  assign idx      = addr_q[AW+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);

  // Next-state and output logic; the WAIT exit edge doubles as the RESP-entry commit edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          cnt_d       = 4'(WAIT_CYCLES);
          req_ready_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = addr_err;
          rsp_rdata_d = 32'h0;
          if (!addr_err) begin
            if (we_q) begin
              mem_we = 1'b1;
            end else begin
              rsp_rdata_d = mem[idx];
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and response registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Word array is not reset; stores commit only on the RESP-entry edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_we;
  logic [31:0] z_req_addr, z_req_wdata;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (z_req_valid),
    .req_ready (z_req_ready),
    .req_we    (z_req_we),
    .req_addr  (z_req_addr),
    .req_wdata (z_req_wdata),
    .rsp_valid (z_rsp_valid),
    .rsp_ready (z_rsp_ready),
    .rsp_rdata (z_rsp_rdata),
    .rsp_err   (z_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance with latency and handshake checks.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    chk({tag, "/ready_before"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    chk({tag, "/ready_after_accept"}, 32'(req_ready), 32'd0);
    chk({tag, "/valid_early"}, 32'(rsp_valid), 32'd0);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk({tag, "/valid_wait"}, 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    chk({tag, "/valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "/rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "/valid_after_hs"}, 32'(rsp_valid), 32'd0);
    chk({tag, "/rdata_after_hs"}, rsp_rdata, 32'h0);
    chk({tag, "/err_after_hs"}, 32'(rsp_err), 32'd0);
    chk({tag, "/ready_after_hs"}, 32'(req_ready), 32'd1);
  endtask

  // Store on the WAIT_CYCLES=0 instance: response one edge after accept.
  task automatic z_store(input string tag, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    chk({tag, "/ready"}, 32'(z_req_ready), 32'd1);
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = addr; z_req_wdata = wdata;
    @(negedge clk);
    z_req_valid = 1'b0;
    chk({tag, "/valid_early"}, 32'(z_rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "/valid"}, 32'(z_rsp_valid), 32'd1);
    chk({tag, "/err"}, 32'(z_rsp_err), 32'd0);
    z_rsp_ready = 1'b1;
    @(negedge clk);
    z_rsp_ready = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'h0; z_req_wdata = 32'h0; z_rsp_ready = 1'b0;

    #22;
    chk("reset/req_ready", 32'(req_ready), 32'd0);
    chk("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset/rsp_rdata", rsp_rdata, 32'h0);
    chk("reset/rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset/ready_still_low", 32'(req_ready), 32'd0);

    do_req("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req("ld10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    do_req("st20", 1'b1, 32'h20, 32'h5A5A0020, 32'h0, 1'b0);
    do_req("st00", 1'b1, 32'h00, 32'hCAFEF00D, 32'h0, 1'b0);

    // Backpressure: response held for 5 cycles while request pulses are ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (W + 1) @(negedge clk);
    chk("bp/valid", 32'(rsp_valid), 32'd1);
    chk("bp/rdata", rsp_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      req_valid = i[0]; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
      @(negedge clk);
      chk("bp/hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp/hold_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp/hold_err", 32'(rsp_err), 32'd0);
      chk("bp/hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0; req_we = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp/release_ready", 32'(req_ready), 32'd1);
    chk("bp/release_valid", 32'(rsp_valid), 32'd0);

    do_req("ld13_mis", 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
    do_req("st22_mis", 1'b1, 32'h22, 32'h11111111, 32'h0, 1'b1);
    do_req("ld20", 1'b0, 32'h20, 32'h0, 32'h5A5A0020, 1'b0);
    do_req("st400_oor", 1'b1, 32'h400, 32'hBADBAD00, 32'h0, 1'b1);
    do_req("st_hi_oor", 1'b1, 32'h80000000, 32'hBADBAD01, 32'h0, 1'b1);
    do_req("ld00", 1'b0, 32'h00, 32'h0, 32'hCAFEF00D, 1'b0);

    // Reset mid-WAIT of a store: must not commit.
    do_req("st08", 1'b1, 32'h08, 32'hAAAA5555, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h08; req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wait/req_ready", 32'(req_ready), 32'd0);
    chk("rst_wait/rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_wait/no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_req("ld08", 1'b0, 32'h08, 32'h0, 32'hAAAA5555, 1'b0);

    // Reset while a load response is pending: outputs drop immediately.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (W + 1) @(negedge clk);
    chk("rst_resp/valid_before", 32'(rsp_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_resp/valid", 32'(rsp_valid), 32'd0);
    chk("rst_resp/rdata", rsp_rdata, 32'h0);
    chk("rst_resp/ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WAIT_CYCLES=0: back-to-back loads, accepts every 3 edges.
    z_store("z_st0", 32'h0, 32'h01020304);
    z_store("z_st4", 32'h4, 32'hA0B0C0D0);
    @(negedge clk);
    z_rsp_ready = 1'b1;
    z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h0;
    @(negedge clk);
    chk("z_b2b/acc1_ready", 32'(z_req_ready), 32'd0);
    chk("z_b2b/acc1_valid", 32'(z_rsp_valid), 32'd0);
    z_req_addr = 32'h4;
    @(negedge clk);
    chk("z_b2b/rsp1_valid", 32'(z_rsp_valid), 32'd1);
    chk("z_b2b/rsp1_rdata", z_rsp_rdata, 32'h01020304);
    @(negedge clk);
    chk("z_b2b/hs1_valid", 32'(z_rsp_valid), 32'd0);
    chk("z_b2b/hs1_ready", 32'(z_req_ready), 32'd1);
    @(negedge clk);
    chk("z_b2b/acc2_ready", 32'(z_req_ready), 32'd0);
    z_req_valid = 1'b0;
    @(negedge clk);
    chk("z_b2b/rsp2_valid", 32'(z_rsp_valid), 32'd1);
    chk("z_b2b/rsp2_rdata", z_rsp_rdata, 32'hA0B0C0D0);
    @(negedge clk);
    chk("z_b2b/hs2_ready", 32'(z_req_ready), 32'd1);
    chk("z_b2b/hs2_valid", 32'(z_rsp_valid), 32'd0);
    z_rsp_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's load/store requests: the target end of the core's data-memory access path.
- Accepts one request at a time over a valid/ready request channel.
- Models a configurable access latency, commits stores or reads the word array, then returns a response over a valid/ready response channel.
- Lets the core and memory controller be exercised against realistic multi-cycle memory timing.

Parameters:
DEPTH, 256, number of 32-bit words; power of two, at least 2; word index width AW = log2(DEPTH)
WAIT_CYCLES, 2, extra cycles between request accept and response (0..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data
rsp_valid  out  1  response present
rsp_ready  in  1  core accepts response
rsp_rdata  out  32  load data; 0 for stores and errors
rsp_err  out  1  request was misaligned or out of range

Behaviour:
- States: IDLE, WAIT, RESP. A 4-bit wait counter cnt.
- Reset (rst_n low, asynchronous) drives state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cnt=0. Memory array contents are not reset (undefined).
- req_ready is a register. It becomes 1 on the first rising edge after rst_n deasserts and stays 1 while in IDLE.
- Accept on any edge with req_valid && req_ready in IDLE:
  - latch we, addr and wdata;
  - clear req_ready on the same edge;
  - go to WAIT with cnt=WAIT_CYCLES, or go directly to RESP handling if WAIT_CYCLES=0.
- WAIT: cnt decrements each edge. Leave WAIT on the edge where cnt==0.
- Latency: if acceptance occurs at edge N, rsp_valid rises on edge N+WAIT_CYCLES+1.
- Entry into RESP (single edge) does all of the following:
  - err = (addr[1:0]!=0) || (addr[31:2] >= DEPTH).
  - Store without error: mem[addr[AW+1:2]] <= wdata; rsp_rdata=0.
  - Load without error: rsp_rdata = mem[index], i.e. the value before any store committed on that same edge (none possible, single outstanding).
  - Error: no memory write, rsp_rdata=0, rsp_err=1.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1 at an edge.
  - On that handshake edge: rsp_valid=0, rsp_err=0, rsp_rdata=0, state=IDLE, req_ready=1.
  - The earliest next accept is therefore one edge after the response handshake.
- req_valid is ignored while req_ready=0. Request signals are not required to stay stable after acceptance.
- rsp_ready while rsp_valid=0 is ignored.
- Single outstanding transaction; no reordering. A load after a store to the same address returns the stored data.
- Reset mid-operation (WAIT or RESP): abort immediately. A store whose RESP-entry edge has not occurred is not committed; a store already committed stays committed. No response is produced after reset.
- Address bits above AW+1 participate only in the range check; no aliasing.

Test Plan:
- WAIT_CYCLES=2: store 0xDEADBEEF to 0x10 accepted at edge N -> rsp_valid at N+3, rsp_err=0, rsp_rdata=0. Then load 0x10 -> rsp_rdata=0xDEADBEEF at accept+3.
- Misaligned load 0x13 and store 0x22 -> rsp_err=1, rsp_rdata=0. A subsequent load of 0x20 returns its prior value unchanged.
- Out-of-range store to 0x400 with DEPTH=256 -> rsp_err=1, no write. Load 0x000 is unaffected; no aliasing.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 throughout; req_valid pulses are ignored. Release rsp_ready -> req_ready=1 on the next edge.
- Reset mid-WAIT of a store of 0x12345678 to 0x08 (previous value 0xAAAA5555) -> outputs go to reset values immediately. After reset, a load of 0x08 returns 0xAAAA5555.
- WAIT_CYCLES=0, back-to-back loads with rsp_ready held 1 -> each response arrives 1 edge after its accept; accepts occur every 3 edges.
